// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the F/D/E/M/W pipeline: stall/bubble/flush
// arbitration, execute-stage operand forwarding, memory-wait FSM with watchdog, perf counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic             d_uses_rs1,
    input  logic             d_uses_rs2,
    input  logic             e_valid,
    input  logic             e_is_load,
    input  logic [4:0]       e_rd,
    input  logic             e_br_taken,
    input  logic [4:0]       m_rd,
    input  logic [4:0]       w_rd,
    input  logic             m_wb_en,
    input  logic             w_wb_en,
    input  logic             m_req,
    input  logic             m_ready,
    output logic             f_stall,
    output logic             d_stall,
    output logic             e_stall,
    output logic             m_stall,
    output logic             e_bubble,
    output logic             d_flush,
    output logic             w_bubble,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WCNT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;
    logic              haz_mw, haz_br, haz_lu;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (m_wb_en && m_rd != 5'd0 && m_rd == rs)
            return 2'd1;
        else if (w_wb_en && w_rd != 5'd0 && w_rd == rs)
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign haz_mw = m_req && !m_ready && (state != S_ERR);
    assign haz_br = e_br_taken;
    assign haz_lu = e_valid && e_is_load && (e_rd != 5'd0) &&
                    ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd));

    // A single prioritised response per cycle; ERR overrides everything until reset.
    always_comb begin
        // NOTE: every output gets a default first so no path through the if-chain infers a latch.
        f_stall   = 1'b0;
        d_stall   = 1'b0;
        e_stall   = 1'b0;
        m_stall   = 1'b0;
        e_bubble  = 1'b0;
        d_flush   = 1'b0;
        w_bubble  = 1'b0;
        fwd_a_sel = 2'd0;
        fwd_b_sel = 2'd0;
        if (!reset) begin
            if (state == S_ERR || haz_mw) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_stall  = 1'b1;
                m_stall  = 1'b1;
                w_bubble = 1'b1;
            end else if (haz_br) begin
                d_flush  = 1'b1;
                e_bubble = 1'b1;
            end else if (haz_lu) begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                e_bubble = 1'b1;
            end
            fwd_a_sel = fwd_sel(d_rs1);
            fwd_b_sel = fwd_sel(d_rs2);
        end
    end

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            S_RUN: begin
                if (haz_mw) begin
                    state_nxt = S_WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            S_WAIT: begin
                if (haz_mw) begin
                    if (wcnt == WCNT_LIMIT)
                        state_nxt = S_ERR;
                    else
                        wcnt_nxt = wcnt + WCNT_W'(1);
                end else if (m_ready) begin
                    state_nxt = S_RUN;
                    wcnt_nxt  = '0;
                end
            end
            default: begin
                state_nxt = S_ERR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_RUN;
            wcnt      <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            wcnt    <= wcnt_nxt;
            mem_err <= mem_err || (state_nxt == S_ERR);
            if (f_stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (d_flush && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 4;
    localparam int CMAX    = (1 << CW) - 1;

    localparam logic [6:0] CTL_NONE = 7'b0000000;
    localparam logic [6:0] CTL_MW   = 7'b1111001;
    localparam logic [6:0] CTL_BR   = 7'b0000110;
    localparam logic [6:0] CTL_LU   = 7'b1100100;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    d_rs1, d_rs2, e_rd, m_rd, w_rd;
    logic          d_uses_rs1, d_uses_rs2, e_valid, e_is_load, e_br_taken;
    logic          m_wb_en, w_wb_en, m_req, m_ready;
    logic          f_stall, d_stall, e_stall, m_stall, e_bubble, d_flush, w_bubble;
    logic [1:0]    fwd_a_sel, fwd_b_sel;
    logic          mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctl;

    int n_pass  = 0;
    int n_total = 0;

    assign ctl = {f_stall, d_stall, e_stall, m_stall, e_bubble, d_flush, w_bubble};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
        .e_valid(e_valid), .e_is_load(e_is_load), .e_rd(e_rd), .e_br_taken(e_br_taken),
        .m_rd(m_rd), .w_rd(w_rd), .m_wb_en(m_wb_en), .w_wb_en(w_wb_en),
        .m_req(m_req), .m_ready(m_ready),
        .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
        .e_bubble(e_bubble), .d_flush(d_flush), .w_bubble(w_bubble),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic clear_inputs();
        d_rs1 = 0; d_rs2 = 0; e_rd = 0; m_rd = 0; w_rd = 0;
        d_uses_rs1 = 0; d_uses_rs2 = 0; e_valid = 0; e_is_load = 0; e_br_taken = 0;
        m_wb_en = 0; w_wb_en = 0; m_req = 0; m_ready = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Forwarding source as the pipeline sees it: youngest in-flight writer wins, x0 never.
    function automatic logic [1:0] fwd_model(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (m_wb_en && m_rd == rs) return 2'd1;
        if (w_wb_en && w_rd == rs) return 2'd2;
        return 2'd0;
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        e_br_taken = 1; m_req = 1; d_rs1 = 3; m_rd = 3; m_wb_en = 1;
        #1;
        n_total++;
        if ({ctl, fwd_a_sel} !== 9'd0) $display("FAIL reset_outputs got=%b exp=%b", {ctl, fwd_a_sel}, 9'd0);
        else n_pass++;
        tick();
        n_total++;
        if ({mem_err, stall_cnt, flush_cnt} !== '0)
            $display("FAIL reset_regs got err=%b sc=%0d fc=%0d exp 0/0/0", mem_err, stall_cnt, flush_cnt);
        else n_pass++;
        reset = 1'b0;
        clear_inputs();
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL reset_release got=%b exp=%b", ctl, CTL_NONE);
        else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        e_valid = 1; e_is_load = 1; e_rd = 5; d_uses_rs1 = 1; d_rs1 = 5;
        #1;
        n_total++;
        if (ctl !== CTL_LU) $display("FAIL load_use_stall got=%b exp=%b", ctl, CTL_LU);
        else n_pass++;
        tick();
        e_valid = 0; e_is_load = 0; e_rd = 0; m_rd = 5; m_wb_en = 1;
        #1;
        n_total++;
        if ({ctl, fwd_a_sel} !== {CTL_NONE, 2'd1})
            $display("FAIL load_use_next got=%b/%0d exp=%b/1", ctl, fwd_a_sel, CTL_NONE);
        else n_pass++;
        n_total++;
        if (stall_cnt !== CW'(1)) $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
        else n_pass++;
        // load into x0 is never a hazard
        clear_inputs();
        e_valid = 1; e_is_load = 1; e_rd = 0; d_uses_rs2 = 1; d_rs2 = 0;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL load_use_x0 got=%b exp=%b", ctl, CTL_NONE);
        else n_pass++;
    endtask

    task automatic test_branch_lu();
        do_reset();
        e_valid = 1; e_is_load = 1; e_rd = 9; d_uses_rs2 = 1; d_rs2 = 9; e_br_taken = 1;
        #1;
        n_total++;
        if (ctl !== CTL_BR) $display("FAIL branch_lu got=%b exp=%b", ctl, CTL_BR);
        else n_pass++;
        tick();
        clear_inputs();
        n_total++;
        if ({flush_cnt, stall_cnt} !== {CW'(1), CW'(0)})
            $display("FAIL branch_cnt got fc=%0d sc=%0d exp fc=1 sc=0", flush_cnt, stall_cnt);
        else n_pass++;
    endtask

    task automatic test_forward_priority();
        do_reset();
        m_rd = 7; w_rd = 7; m_wb_en = 1; w_wb_en = 1; d_rs2 = 7; d_rs1 = 7;
        #1;
        n_total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) $display("FAIL fwd_m_over_w got=%b exp=0101", {fwd_a_sel, fwd_b_sel});
        else n_pass++;
        m_wb_en = 0;
        #1;
        n_total++;
        if (fwd_b_sel !== 2'd2) $display("FAIL fwd_w got=%0d exp=2", fwd_b_sel);
        else n_pass++;
        m_wb_en = 1; m_rd = 0; w_rd = 0; d_rs2 = 0; d_rs1 = 0;
        #1;
        n_total++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        do_reset();
        m_req = 1; m_ready = 1; e_br_taken = 1;
        #1;
        n_total++;
        if (ctl !== CTL_BR) $display("FAIL zero_wait got=%b exp=%b", ctl, CTL_BR);
        else n_pass++;
        do_reset();
        m_req = 1; m_ready = 0;
        for (int i = 0; i < 3; i++) begin
            e_br_taken = (i == 1);
            #1;
            n_total++;
            if (ctl !== CTL_MW) $display("FAIL mem_wait_%0d got=%b exp=%b", i, ctl, CTL_MW);
            else n_pass++;
            tick();
        end
        e_br_taken = 0;
        m_ready = 1;
        #1;
        n_total++;
        if (ctl !== CTL_NONE) $display("FAIL mem_ready got=%b exp=%b", ctl, CTL_NONE);
        else n_pass++;
        tick();
        n_total++;
        if ({stall_cnt, flush_cnt} !== {CW'(3), CW'(0)})
            $display("FAIL mem_wait_cnt got sc=%0d fc=%0d exp sc=3 fc=0", stall_cnt, flush_cnt);
        else n_pass++;
        // A full-length wait right after must not trip the watchdog if the counter was cleared.
        m_ready = 0;
        repeat (TIMEOUT) tick();
        m_ready = 1;
        tick();
        m_req = 0;
        n_total++;
        if (mem_err !== 1'b0) $display("FAIL mem_wait_rerun got=%b exp=0", mem_err);
        else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        m_req = 1; m_ready = 0;
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            tick();
            n_total++;
            if (mem_err !== (i == TIMEOUT + 1)) $display("FAIL timeout_edge_%0d got=%b exp=%b", i, mem_err, i == TIMEOUT + 1);
            else n_pass++;
        end
        m_ready = 1; e_br_taken = 1;
        #1;
        n_total++;
        if (ctl !== CTL_MW) $display("FAIL err_persist got=%b exp=%b", ctl, CTL_MW);
        else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        #1;
        n_total++;
        if ({mem_err, stall_cnt, flush_cnt, ctl} !== '0)
            $display("FAIL err_reset got err=%b sc=%0d fc=%0d ctl=%b exp all 0", mem_err, stall_cnt, flush_cnt, ctl);
        else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        e_br_taken = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_total++;
            if (int'(flush_cnt) !== ((i < CMAX) ? i : CMAX))
                $display("FAIL flush_sat_%0d got=%0d exp=%0d", i, flush_cnt, (i < CMAX) ? i : CMAX);
            else n_pass++;
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit         merr, mw, lu;
        int         k, sc, fc;
        logic [6:0] ectl;
        logic [1:0] ea, eb;
        do_reset();
        merr = 0; k = 0; sc = 0; fc = 0;
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            d_rs1      = 5'($urandom_range(0, 3));
            d_rs2      = 5'($urandom_range(0, 3));
            e_rd       = 5'($urandom_range(0, 3));
            m_rd       = 5'($urandom_range(0, 3));
            w_rd       = 5'($urandom_range(0, 3));
            d_uses_rs1 = 1'($urandom);
            d_uses_rs2 = 1'($urandom);
            e_valid    = 1'($urandom);
            e_is_load  = 1'($urandom);
            m_wb_en    = 1'($urandom);
            w_wb_en    = 1'($urandom);
            e_br_taken = ($urandom_range(0, 5) == 0);
            m_req      = ($urandom_range(0, 2) == 0);
            m_ready    = 1'($urandom);

            mw = m_req && !m_ready && !merr;
            lu = e_valid && e_is_load && e_rd != 0 &&
                 ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd));
            ectl = CTL_NONE; ea = 0; eb = 0;
            if (!reset) begin
                if (merr || mw)      ectl = CTL_MW;
                else if (e_br_taken) ectl = CTL_BR;
                else if (lu)         ectl = CTL_LU;
                ea = fwd_model(d_rs1);
                eb = fwd_model(d_rs2);
            end
            #1;
            n_total++;
            if ({ctl, fwd_a_sel, fwd_b_sel} !== {ectl, ea, eb})
                $display("FAIL rand_comb_%0d got=%b exp=%b", i, {ctl, fwd_a_sel, fwd_b_sel}, {ectl, ea, eb});
            else n_pass++;

            if (reset) begin
                merr = 0; k = 0; sc = 0; fc = 0;
            end else begin
                if (ectl[6] && sc < CMAX) sc++;
                if (ectl[1] && fc < CMAX) fc++;
                if (!merr) begin
                    if (mw) begin
                        k++;
                        if (k > TIMEOUT) merr = 1;
                    end else if (m_ready) begin
                        k = 0;
                    end
                end
            end
            tick();
            n_total++;
            if ({mem_err, int'(stall_cnt), int'(flush_cnt)} !== {merr, sc, fc})
                $display("FAIL rand_regs_%0d got err=%b sc=%0d fc=%0d exp err=%b sc=%0d fc=%0d",
                         i, mem_err, stall_cnt, flush_cnt, merr, sc, fc);
            else n_pass++;
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_branch_lu();
        test_forward_priority();
        test_mem_wait();
        test_timeout();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the five-stage (F/D/E/M/W) RISC-V core. Each cycle it decides stall, bubble and flush controls for the pipeline registers. It also selects operand forwarding for the execute stage and runs a memory-wait state machine with a timeout watchdog. It keeps saturating performance counters that the trace environment reads. It sits beside the datapath inside `design_wrapper` and is the only block that drives pipeline-register enables and flushes.

## Interface
- MEM_TIMEOUT, 255: maximum consecutive cycles a memory access may wait before an error is flagged.
- CNT_W, 16: width of the performance counters.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- d_rs1, d_rs2  in  5  source registers of the instruction in D.
- d_uses_rs1, d_uses_rs2  in  1  D instruction reads rs1 / rs2.
- e_valid, e_is_load  in  1  E holds a valid instruction / that instruction is a load.
- e_rd  in  5  destination register of the instruction in E.
- e_br_taken  in  1  branch or jump resolved taken in E.
- m_rd, w_rd  in  5  destination registers in M and W.
- m_wb_en, w_wb_en  in  1  M / W will write the register file.
- m_req  in  1  M has a data-memory access outstanding this cycle.
- m_ready  in  1  data memory completes the access this cycle.
- f_stall, d_stall, e_stall, m_stall  out  1  hold the F, F/D, D/E and E/M registers.
- e_bubble  out  1  load a NOP into the D/E register.
- d_flush  out  1  load a NOP into the F/D register.
- w_bubble  out  1  load a NOP into the M/W register.
- fwd_a_sel, fwd_b_sel  out  2  E operand source: 0 = register file, 1 = M result, 2 = W result.
- mem_err  out  1  sticky memory timeout flag.
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

## Operation
- Hazard conditions, evaluated combinationally from current inputs:
  - MW (memory wait) = m_req && !m_ready && state != ERR.
  - BR (branch) = e_br_taken.
  - LU (load-use) = e_valid && e_is_load && e_rd != 0 && ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd)).
- Priority is MW > BR > LU, and only one response is applied per cycle:
  - MW: f_stall = d_stall = e_stall = m_stall = 1, w_bubble = 1. No flush or bubble is issued; BR and LU are deferred until MW clears.
  - BR: d_flush = 1, e_bubble = 1. The two younger instructions are squashed and F loads the target. When LU coincides with BR, BR alone applies.
  - LU: f_stall = d_stall = 1, e_bubble = 1. Each qualifying cycle produces exactly one bubble, and the condition clears naturally once the load reaches M.
- Forwarding, per operand (shown for A; B is identical using d_rs2):
  - 1 if m_wb_en && m_rd != 0 && m_rd == d_rs1.
  - else 2 if w_wb_en && w_rd != 0 && w_rd == d_rs1.
  - else 0.
  - M has precedence over W. x0 never forwards.
- FSM states are RUN, WAIT, ERR; a wait counter (8 bits minimum, large enough to hold MEM_TIMEOUT) is kept.
  - RUN → WAIT when MW. The wait counter loads 1.
  - WAIT stays in WAIT while MW and increments the counter.
  - WAIT → RUN when m_ready. The counter clears.
  - WAIT → ERR when MW and counter == MEM_TIMEOUT.
  - ERR sets mem_err = 1. All stall outputs are forced to 1 permanently, and w_bubble = 1. Only reset leaves ERR.
- Counters:
  - stall_cnt increments on any cycle where f_stall = 1.
  - flush_cnt increments on any cycle where d_flush = 1.
  - Both saturate at 2^CNT_W − 1 and never wrap.

## Timing
- All stall, bubble, flush and forwarding outputs are combinational from inputs and the current state, with zero-cycle latency. They act on the pipeline registers at the same clk edge.
- state, the wait counter, mem_err and the counters update on the rising clk edge.
- While reset = 1, all stall, flush and bubble outputs and fwd_*_sel are forced to 0. At the reset edge, state returns to RUN and mem_err, the wait counter, stall_cnt and flush_cnt return to 0.
- Reset asserted mid-WAIT or in ERR takes effect at the next edge. There is no residual stall in the cycle after reset deasserts.
- m_ready in the same cycle as m_req means a zero-wait access: no stall and no FSM transition.
- A counter already at its maximum stays at its maximum when incremented.

## Test plan
- Load-use: lw x5 in E (e_is_load = 1, e_rd = 5) with D add using rs1 = 5 → exactly one cycle of f_stall = d_stall = e_bubble = 1; the next cycle fwd_a_sel = 1; stall_cnt = 1.
- Branch with simultaneous load-use: e_br_taken = 1 and LU true in the same cycle → d_flush = e_bubble = 1, f_stall = 0; flush_cnt = 1.
- Forward priority: m_rd = w_rd = 7, both wb_en = 1, d_rs2 = 7 → fwd_b_sel = 1. With rd = 0 on both → fwd_b_sel = 0.
- Memory wait: m_req = 1 with m_ready low for 3 cycles, then high → stall outputs high and w_bubble high for those 3 cycles, low on the m_ready cycle; stall_cnt = 3; state returns to RUN.
- Timeout: MEM_TIMEOUT = 4 and m_ready held low → mem_err rises after the 5th stalled edge, and stalls persist once m_ready rises. Pulsing reset for 1 cycle → mem_err = 0 and all counters = 0.
- Saturation: CNT_W = 4 and 20 consecutive branch flushes → flush_cnt = 15.
